// File: rtl/operand_stream_bank.sv
// Operand store and feeder for the MAC-grid matrix multiplier: loads W then X over a
// valid/ready stream, clears the active MACs, then broadcasts one inner-product step per cycle.
module operand_stream_bank #(
  parameter int DATA_W  = 4,
  parameter int MAX_DIM = 3,
  localparam int DIM_W  = $clog2(MAX_DIM+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DIM_W-1:0]              row_w,
  input  logic [DIM_W-1:0]              col_w,
  input  logic [DIM_W-1:0]              row_x,
  input  logic [DIM_W-1:0]              col_x,
  input  logic                          clear_mem,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          busy,
  output logic                          err_dim,
  output logic [MAX_DIM*DATA_W-1:0]     w_out,
  output logic [MAX_DIM*DATA_W-1:0]     x_out,
  output logic                          feed_valid,
  output logic [MAX_DIM*MAX_DIM-1:0]    ld_mac,
  output logic [MAX_DIM*MAX_DIM-1:0]    clear_mac,
  output logic                          unload_res
);

  localparam int CNT_W = $clog2(MAX_DIM*MAX_DIM+1);
  localparam int NM    = MAX_DIM*MAX_DIM;
  localparam int OW    = MAX_DIM*DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_X, S_CLEAR, S_FEED, S_DONE} state_t;
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_W-1:0] mem_t;

  state_t            state_q, state_d;
  mem_t              w_mem_q, w_mem_d, x_mem_q, x_mem_d;
  logic [DIM_W-1:0]  rw_q, rw_d, cw_q, cw_d, rx_q, rx_d, cx_q, cx_d;
  logic [DIM_W-1:0]  r_q, r_d, c_q, c_d, k_q, k_d;
  logic [CNT_W-1:0]  addr_q, addr_d;
  logic              busy_q, busy_d, err_dim_q, err_dim_d;
  logic              feed_valid_q, feed_valid_d, unload_res_q, unload_res_d;
  logic [OW-1:0]     w_out_q, w_out_d, x_out_q, x_out_d;
  logic [NM-1:0]     ld_mac_q, ld_mac_d, clear_mac_q, clear_mac_d;

  logic              accept, dim_bad;
  logic [DIM_W-1:0]  ncol;
  logic [CNT_W-1:0]  total;
  logic [NM-1:0]     mask;

  assign in_ready = (state_q == S_LOAD_W || state_q == S_LOAD_X) && !clear_mem;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    w_mem_d      = w_mem_q;
    x_mem_d      = x_mem_q;
    rw_d         = rw_q;
    cw_d         = cw_q;
    rx_d         = rx_q;
    cx_d         = cx_q;
    r_d          = r_q;
    c_d          = c_q;
    k_d          = k_q;
    addr_d       = addr_q;
    err_dim_d    = 1'b0;
    feed_valid_d = 1'b0;
    unload_res_d = 1'b0;
    ld_mac_d     = '0;
    clear_mac_d  = '0;
    w_out_d      = '0;
    x_out_d      = '0;
    mask         = '0;

    // LOAD_W and LOAD_X share one write/advance path; only the geometry differs
    ncol  = (state_q == S_LOAD_W) ? cw_q : cx_q;
    total = (state_q == S_LOAD_W) ? CNT_W'(rw_q) * CNT_W'(cw_q)
                                  : CNT_W'(rx_q) * CNT_W'(cx_q);
    dim_bad = (row_w == '0) || (col_w == '0) || (row_x == '0) || (col_x == '0) ||
              (int'(row_w) > MAX_DIM) || (int'(col_w) > MAX_DIM) ||
              (int'(row_x) > MAX_DIM) || (int'(col_x) > MAX_DIM) ||
              (col_w != row_x);

    if (clear_mem) begin
      state_d = S_IDLE;
      w_mem_d = '0;
      x_mem_d = '0;
      addr_d  = '0;
      r_d     = '0;
      c_d     = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (dim_bad) begin
              err_dim_d = 1'b1;
            end else begin
              rw_d    = row_w;
              cw_d    = col_w;
              rx_d    = row_x;
              cx_d    = col_x;
              addr_d  = '0;
              r_d     = '0;
              c_d     = '0;
              state_d = S_LOAD_W;
            end
          end
        end
        S_LOAD_W, S_LOAD_X: begin
          if (accept) begin
            if (state_q == S_LOAD_W) w_mem_d[r_q][c_q] = in_data;
            else                     x_mem_d[r_q][c_q] = in_data;
            if (addr_q == total - CNT_W'(1)) begin
              addr_d  = '0;
              r_d     = '0;
              c_d     = '0;
              state_d = (state_q == S_LOAD_W) ? S_LOAD_X : S_CLEAR;
            end else begin
              addr_d = addr_q + CNT_W'(1);
              if (c_q == ncol - DIM_W'(1)) begin
                c_d = '0;
                r_d = r_q + DIM_W'(1);
              end else begin
                c_d = c_q + DIM_W'(1);
              end
            end
          end
        end
        S_CLEAR: begin
          k_d     = '0;
          state_d = S_FEED;
        end
        S_FEED: begin
          if (k_q == cw_q - DIM_W'(1)) state_d = S_DONE;
          else                         k_d = k_q + DIM_W'(1);
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    for (int i = 0; i < MAX_DIM; i++)
      for (int j = 0; j < MAX_DIM; j++)
        mask[i*MAX_DIM+j] = (i < int'(rw_q)) && (j < int'(cx_q));

    // Outputs are registered from the next state so they line up with the state they describe
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_CLEAR: clear_mac_d = mask;
      S_FEED: begin
        feed_valid_d = 1'b1;
        ld_mac_d     = mask;
        for (int i = 0; i < MAX_DIM; i++)
          if (i < int'(rw_q)) w_out_d[i*DATA_W +: DATA_W] = w_mem_q[i][k_d];
        for (int j = 0; j < MAX_DIM; j++)
          if (j < int'(cx_q)) x_out_d[j*DATA_W +: DATA_W] = x_mem_q[k_d][j];
      end
      S_DONE:  unload_res_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      w_mem_q      <= '0;
      x_mem_q      <= '0;
      rw_q         <= '0;
      cw_q         <= '0;
      rx_q         <= '0;
      cx_q         <= '0;
      r_q          <= '0;
      c_q          <= '0;
      k_q          <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      err_dim_q    <= 1'b0;
      feed_valid_q <= 1'b0;
      unload_res_q <= 1'b0;
      w_out_q      <= '0;
      x_out_q      <= '0;
      ld_mac_q     <= '0;
      clear_mac_q  <= '0;
    end else begin
      state_q      <= state_d;
      w_mem_q      <= w_mem_d;
      x_mem_q      <= x_mem_d;
      rw_q         <= rw_d;
      cw_q         <= cw_d;
      rx_q         <= rx_d;
      cx_q         <= cx_d;
      r_q          <= r_d;
      c_q          <= c_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      err_dim_q    <= err_dim_d;
      feed_valid_q <= feed_valid_d;
      unload_res_q <= unload_res_d;
      w_out_q      <= w_out_d;
      x_out_q      <= x_out_d;
      ld_mac_q     <= ld_mac_d;
      clear_mac_q  <= clear_mac_d;
    end
  end

  assign busy       = busy_q;
  assign err_dim    = err_dim_q;
  assign feed_valid = feed_valid_q;
  assign unload_res = unload_res_q;
  assign w_out      = w_out_q;
  assign x_out      = x_out_q;
  assign ld_mac     = ld_mac_q;
  assign clear_mac  = clear_mac_q;

endmodule

// File: tb/tb_operand_stream_bank.sv
// Bench for operand_stream_bank: a scoreboard of expected feed steps is filled from a
// matrix model when a job is issued and drained by a monitor whenever feed_valid is high.
module tb_operand_stream_bank;
  localparam int DATA_W  = 4;
  localparam int MAX_DIM = 3;
  localparam int DIM_W   = 2;
  localparam int OW      = MAX_DIM*DATA_W;
  localparam int NM      = MAX_DIM*MAX_DIM;

  logic              clk = 1'b0, rst = 1'b1;
  logic              start = 1'b0, clear_mem = 1'b0, in_valid = 1'b0;
  logic [DIM_W-1:0]  row_w = '0, col_w = '0, row_x = '0, col_x = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, busy, err_dim, feed_valid, unload_res;
  logic [OW-1:0]     w_out, x_out;
  logic [NM-1:0]     ld_mac, clear_mac;

  operand_stream_bank #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .row_w(row_w), .col_w(col_w),
    .row_x(row_x), .col_x(col_x), .clear_mem(clear_mem), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .busy(busy), .err_dim(err_dim),
    .w_out(w_out), .x_out(x_out), .feed_valid(feed_valid), .ld_mac(ld_mac),
    .clear_mac(clear_mac), .unload_res(unload_res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] w;
    logic [OW-1:0] x;
    logic [NM-1:0] ld;
  } exp_t;

  exp_t          sbq[$];
  int            checks = 0, errors = 0;
  int            cyc = 0, unload_cnt = 0, clear_cnt = 0, clear_cyc = -1, first_feed_cyc = -1;
  logic [NM-1:0] clear_val = '0;
  int            wv[9], xv[9];

  function automatic logic [NM-1:0] mask_of(int rw, int cx);
    logic [NM-1:0] m = '0;
    for (int i = 0; i < rw; i++)
      for (int j = 0; j < cx; j++) m[i*MAX_DIM+j] = 1'b1;
    return m;
  endfunction

  // Monitor: drains the scoreboard on every feed step and tracks pulses
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (unload_res) unload_cnt++;
      if (clear_mac != '0) begin
        clear_cnt++;
        clear_val = clear_mac;
        clear_cyc = cyc;
      end
      if (feed_valid) begin
        if (first_feed_cyc < 0) first_feed_cyc = cyc;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL feed_unexpected w_out=%h x_out=%h required no feed step", w_out, x_out);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (w_out !== e.w || x_out !== e.x || ld_mac !== e.ld) begin
            errors++;
            $display("FAIL feed_step w=%h x=%h ld=%h required w=%h x=%h ld=%h",
                     w_out, x_out, ld_mac, e.w, e.x, e.ld);
          end
        end
      end
    end
  end

  task automatic push_exp(input int rw, input int cw, input int cx);
    exp_t e;
    for (int k = 0; k < cw; k++) begin
      e.w = '0;
      e.x = '0;
      for (int i = 0; i < rw; i++) e.w[i*DATA_W +: DATA_W] = DATA_W'(wv[i*cw+k]);
      for (int j = 0; j < cx; j++) e.x[j*DATA_W +: DATA_W] = DATA_W'(xv[k*cx+j]);
      e.ld = mask_of(rw, cx);
      sbq.push_back(e);
    end
  endtask

  task automatic do_start(input int rw, input int cw, input int rx, input int cx);
    @(posedge clk); #1;
    start = 1'b1;
    row_w = DIM_W'(rw); col_w = DIM_W'(cw); row_x = DIM_W'(rx); col_x = DIM_W'(cx);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams W then X; in_valid optionally toggles every cycle
  task automatic stream(input int n, input int nw, input bit tog, output int acc);
    int t = 0;
    acc = 0;
    while (acc < n && t < 200) begin
      in_valid = tog ? (t % 2 == 0) : 1'b1;
      in_data  = (acc < nw) ? DATA_W'(wv[acc]) : DATA_W'(xv[acc-nw]);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (acc < n) begin
      checks++; errors++;
      $display("FAIL stream_timeout accepted=%0d required=%0d", acc, n);
    end
  endtask

  task automatic run_job(input int rw, input int cw, input int rx, input int cx,
                         input bit tog, output int acc);
    int u0 = unload_cnt;
    int t = 0;
    clear_cnt = 0;
    clear_cyc = -1;
    first_feed_cyc = -1;
    push_exp(rw, cw, cx);
    do_start(rw, cw, rx, cx);
    stream(rw*cw + rx*cx, rw*cw, tog, acc);
    while (!unload_res && t < 40) begin
      @(negedge clk); #1;
      t++;
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (unload_cnt - u0 != 1) begin
      errors++;
      $display("FAIL unload_pulses got=%0d required=1", unload_cnt - u0);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL feed_steps_missing left=%0d required=0", sbq.size());
      sbq.delete();
    end
    checks++;
    if (clear_cnt != 1 || clear_val !== mask_of(rw, cx)) begin
      errors++;
      $display("FAIL clear_mac cycles=%0d val=%h required cycles=1 val=%h",
               clear_cnt, clear_val, mask_of(rw, cx));
    end
    checks++;
    if (first_feed_cyc != clear_cyc + 1) begin
      errors++;
      $display("FAIL clear_to_feed first_feed=%0d clear=%0d required first_feed=clear+1",
               first_feed_cyc, clear_cyc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_job got=%b required=0", busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, in_ready, err_dim, feed_valid, unload_res, w_out, x_out, ld_mac, clear_mac} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b rdy=%b w=%h x=%h ld=%h clr=%h required all 0",
               busy, in_ready, w_out, x_out, ld_mac, clear_mac);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_2x2();
    int acc;
    wv = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    xv = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    run_job(2, 2, 2, 2, 1'b0, acc);
  endtask

  task automatic test_identity_3x3();
    int acc;
    wv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    xv = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    run_job(3, 3, 3, 3, 1'b0, acc);
  endtask

  task automatic test_toggle_1x3_3x2();
    int acc;
    wv = '{1, 2, 3, 0, 0, 0, 0, 0, 0};
    xv = '{4, 5, 6, 7, 8, 9, 0, 0, 0};
    run_job(1, 3, 3, 2, 1'b1, acc);
    checks++;
    if (acc != 9) begin
      errors++;
      $display("FAIL toggle_accepts got=%0d required=9", acc);
    end
  endtask

  task automatic test_bad_dims();
    int bad[2][4] = '{'{2, 2, 3, 2}, '{0, 2, 2, 2}};
    for (int c = 0; c < 2; c++) begin
      do_start(bad[c][0], bad[c][1], bad[c][2], bad[c][3]);
      @(negedge clk);
      checks++;
      if (err_dim !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bad_dim_%0d err=%b busy=%b rdy=%b required err=1 busy=0 rdy=0",
                 c, err_dim, busy, in_ready);
      end
      @(negedge clk);
      checks++;
      if (err_dim !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bad_dim_pulse_%0d err=%b busy=%b required err=0 busy=0", c, err_dim, busy);
      end
    end
  endtask

  task automatic test_clear_mem_feed();
    int acc, t = 0;
    int u0 = unload_cnt;
    wv = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    xv = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    push_exp(2, 2, 2);
    do_start(2, 2, 2, 2);
    stream(8, 4, 1'b0, acc);
    while (!feed_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    clear_mem = 1'b1;
    @(posedge clk); #1;
    clear_mem = 1'b0;
    @(negedge clk);
    checks++;
    if (feed_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_mem_abort feed_valid=%b busy=%b required 0 0", feed_valid, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (unload_cnt != u0 || sbq.size() != 0) begin
      errors++;
      $display("FAIL clear_mem_no_unload unloads=%0d left=%0d required 0 0", unload_cnt - u0, sbq.size());
      sbq.delete();
    end
    run_job(2, 2, 2, 2, 1'b0, acc);
  endtask

  task automatic test_rst_mid_load();
    int acc;
    wv = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    xv = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    do_start(2, 2, 2, 2);
    stream(5, 4, 1'b0, acc);
    in_valid = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, in_ready, err_dim, feed_valid, unload_res, w_out, x_out, ld_mac, clear_mac} !== '0) begin
      errors++;
      $display("FAIL rst_mid_job busy=%b rdy=%b fv=%b ld=%h required all 0",
               busy, in_ready, feed_valid, ld_mac);
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    run_job(2, 2, 2, 2, 1'b0, acc);
  endtask

  initial begin
    test_reset();
    test_basic_2x2();
    test_identity_3x3();
    test_toggle_1x3_3x2();
    test_bad_dims();
    test_clear_mem_feed();
    test_rst_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached required bench completion");
    $fatal(1);
  end

endmodule
